// File: rtl/game_pkg.sv
// game_pkg: shared game constants, round-sequencer state encoding and winner codes.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        OVER    = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

    localparam int SCREEN_W    = 1024;
    localparam int EDGE_MARGIN = 40;
    localparam int PLAYER_W    = 64;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: registers a level input once and flags the rising edge of the registered copy.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic q;
    logic q_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q   <= 1'b0;
            q_d <= 1'b0;
        end else begin
            q   <= d;
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;
endmodule

// File: rtl/round_control.sv
// round_control: round/match sequencer turning kills and edge exits into scores,
// frame-timed respawn delays, board scrolls and match-over detection.
module round_control
    import game_pkg::*;
#(
    parameter int RESPAWN_FRAMES = 60,
    parameter int WIN_BOARD      = 3,
    parameter int SCORE_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               dead_L,
    input  logic               dead_R,
    input  logic               pos_reset,
    input  logic [2:0]         board_controller,
    output logic               freeze,
    output logic               respawn_L,
    output logic               respawn_R,
    output logic               scroll,
    output logic [SCORE_W-1:0] score_L,
    output logic [SCORE_W-1:0] score_R,
    output logic [1:0]         winner,
    output logic               game_over
);
    localparam int CW = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(RESPAWN_FRAMES - 1);
    localparam logic signed [2:0] WB = 3'(WIN_BOARD);

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic mark_l, mark_l_n, mark_r, mark_r_n;
    logic freeze_n, rsp_l_n, rsp_r_n, scroll_n, over_n;
    logic [SCORE_W-1:0] score_l_n, score_r_n;
    logic [1:0] winner_n;
    logic kill_l, kill_r, edge_pos;
    logic signed [2:0] board;

    assign board = board_controller;

    edge_detect u_dead_l (.clk(clk), .reset(reset), .d(dead_L),    .rise(kill_l));
    edge_detect u_dead_r (.clk(clk), .reset(reset), .d(dead_R),    .rise(kill_r));
    edge_detect u_pos    (.clk(clk), .reset(reset), .d(pos_reset), .rise(edge_pos));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mark_l    <= 1'b0;
            mark_r    <= 1'b0;
            freeze    <= 1'b1;
            respawn_L <= 1'b0;
            respawn_R <= 1'b0;
            scroll    <= 1'b0;
            score_L   <= '0;
            score_R   <= '0;
            winner    <= WIN_NONE;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mark_l    <= mark_l_n;
            mark_r    <= mark_r_n;
            freeze    <= freeze_n;
            respawn_L <= rsp_l_n;
            respawn_R <= rsp_r_n;
            scroll    <= scroll_n;
            score_L   <= score_l_n;
            score_R   <= score_r_n;
            winner    <= winner_n;
            game_over <= over_n;
        end
    end

    // cnt doubles as the two-cycle settle timer in ADVANCE and the frame counter in WAIT
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mark_l_n  = mark_l;
        mark_r_n  = mark_r;
        freeze_n  = freeze;
        rsp_l_n   = 1'b0;
        rsp_r_n   = 1'b0;
        scroll_n  = 1'b0;
        score_l_n = score_L;
        score_r_n = score_R;
        winner_n  = winner;
        over_n    = game_over;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = PLAY;
                    rsp_l_n  = 1'b1;
                    rsp_r_n  = 1'b1;
                    freeze_n = 1'b0;
                end
            end
            PLAY: begin
                if (edge_pos) begin
                    state_n  = ADVANCE;
                    freeze_n = 1'b1;
                    cnt_n    = '0;
                end else if (kill_l || kill_r) begin
                    state_n  = WAIT;
                    freeze_n = 1'b1;
                    cnt_n    = '0;
                    mark_l_n = kill_l;
                    mark_r_n = kill_r;
                    if (kill_l && !kill_r)
                        score_r_n = (&score_R) ? score_R : score_R + SCORE_W'(1);
                    if (kill_r && !kill_l)
                        score_l_n = (&score_L) ? score_L : score_L + SCORE_W'(1);
                end
            end
            WAIT: begin
                if (frame_tick) begin
                    if (cnt == LAST) begin
                        state_n  = PLAY;
                        rsp_l_n  = mark_l;
                        rsp_r_n  = mark_r;
                        mark_l_n = 1'b0;
                        mark_r_n = 1'b0;
                        freeze_n = 1'b0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            ADVANCE: begin
                if (cnt == CW'(1)) begin
                    if (board >= WB) begin
                        state_n  = OVER;
                        winner_n = WIN_L;
                        over_n   = 1'b1;
                    end else if (board <= -WB) begin
                        state_n  = OVER;
                        winner_n = WIN_R;
                        over_n   = 1'b1;
                    end else begin
                        state_n  = WAIT;
                        scroll_n = 1'b1;
                        mark_l_n = 1'b1;
                        mark_r_n = 1'b1;
                        cnt_n    = '0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            OVER: begin
                if (start) begin
                    state_n   = PLAY;
                    score_l_n = '0;
                    score_r_n = '0;
                    winner_n  = WIN_NONE;
                    over_n    = 1'b0;
                    rsp_l_n   = 1'b1;
                    rsp_r_n   = 1'b1;
                    freeze_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_round_control.sv
// tb_round_control: scoreboard bench for round_control with RESPAWN_FRAMES=4.
module tb_round_control;
    import game_pkg::*;

    localparam int RF = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_tick = 1'b0;
    logic start = 1'b0;
    logic dead_L = 1'b0;
    logic dead_R = 1'b0;
    logic pos_reset = 1'b0;
    logic [2:0] board_controller = 3'd0;
    logic freeze, respawn_L, respawn_R, scroll, game_over;
    logic [3:0] score_L, score_R;
    logic [1:0] winner;

    int checks = 0;
    int failures = 0;
    int exp_sl = 0;
    int exp_sr = 0;

    typedef struct packed {
        logic       rl;
        logic       rr;
        logic       sc;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] w;
        logic       go;
        logic       fz;
    } snap_t;

    snap_t exp_q[$];
    snap_t got, e;

    always #5 clk = ~clk;

    round_control #(.RESPAWN_FRAMES(RF), .WIN_BOARD(3), .SCORE_W(4)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .dead_L(dead_L), .dead_R(dead_R), .pos_reset(pos_reset),
        .board_controller(board_controller), .freeze(freeze),
        .respawn_L(respawn_L), .respawn_R(respawn_R), .scroll(scroll),
        .score_L(score_L), .score_R(score_R), .winner(winner), .game_over(game_over)
    );

    function automatic snap_t obs();
        return {respawn_L, respawn_R, scroll, score_L, score_R, winner, game_over, freeze};
    endfunction

    function automatic snap_t mk(logic rl, logic rr, logic sc, logic [1:0] w, logic go, logic fz);
        return {rl, rr, sc, 4'(exp_sl), 4'(exp_sr), w, go, fz};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    // advances until any output leaves its steady value (pulse, score, winner, over, freeze)
    task automatic wait_event(input string name, output int n);
        snap_t base;
        base = obs();
        base.rl = 1'b0;
        base.rr = 1'b0;
        base.sc = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (obs() === base && n < 30);
        if (obs() === base) begin
            checks++;
            failures++;
            $display("FAIL %s timeout after %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL reset_vals got=%h exp=%h", got, e); end
        reset = 1'b1;
        tick();
        pulse_tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL idle_after_release got=%h exp=%h", got, e); end
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(mk(1, 1, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL start_pulse got=%h exp=%h", got, e); end
        tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL start_pulse_end got=%h exp=%h", got, e); end
    endtask

    task automatic test_single_kill();
        int n;
        dead_L = 1'b1;
        exp_sr++;
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        wait_event("kill_l", n);
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL kill_l_score got=%h exp=%h", got, e); end
        repeat (3) tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL kill_l_once got=%h exp=%h", got, e); end
        repeat (RF - 1) pulse_tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL kill_l_early got=%h exp=%h", got, e); end
        pulse_tick();
        exp_q.push_back(mk(1, 0, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL kill_l_respawn got=%h exp=%h", got, e); end
        repeat (3) tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL kill_l_no_retrigger got=%h exp=%h", got, e); end
        dead_L = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_double_kill();
        dead_L = 1'b1;
        dead_R = 1'b1;
        tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL double_kill_scores got=%h exp=%h", got, e); end
        repeat (RF - 1) pulse_tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL double_kill_tick_ignored got=%h exp=%h", got, e); end
        pulse_tick();
        exp_q.push_back(mk(1, 1, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL double_kill_respawn got=%h exp=%h", got, e); end
        dead_L = 1'b0;
        dead_R = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_advance();
        int n;
        board_controller = 3'd1;
        pos_reset = 1'b1;
        tick();
        board_controller = 3'd2;
        tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL adv_freeze got=%h exp=%h", got, e); end
        exp_q.push_back(mk(0, 0, 1, WIN_NONE, 0, 1));
        wait_event("adv_scroll", n);
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL adv_scroll got=%h exp=%h", got, e); end
        checks++;
        if (n !== 2) begin failures++; $display("FAIL adv_latency got=%0d exp=2", n); end
        pos_reset = 1'b0;
        tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL adv_scroll_end got=%h exp=%h", got, e); end
        repeat (RF) pulse_tick();
        exp_q.push_back(mk(1, 1, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL adv_respawn got=%h exp=%h", got, e); end
        tick();
        pos_reset = 1'b1;
        tick();
        board_controller = 3'd3;
        tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL win_freeze got=%h exp=%h", got, e); end
        exp_q.push_back(mk(0, 0, 0, WIN_L, 1, 1));
        wait_event("win_left", n);
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL win_left got=%h exp=%h", got, e); end
        pos_reset = 1'b0;
        repeat (2) pulse_tick();
        exp_q.push_back(mk(0, 0, 0, WIN_L, 1, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL over_held got=%h exp=%h", got, e); end
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_sl = 0;
        exp_sr = 0;
        exp_q.push_back(mk(1, 1, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL restart got=%h exp=%h", got, e); end
        tick();
        pos_reset = 1'b1;
        tick();
        board_controller = 3'b101;
        tick();
        exp_q.push_back(mk(0, 0, 0, WIN_R, 1, 1));
        wait_event("win_right", n);
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL win_right got=%h exp=%h", got, e); end
        pos_reset = 1'b0;
        board_controller = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(mk(1, 1, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL restart2 got=%h exp=%h", got, e); end
        tick();
    endtask

    task automatic test_pos_and_kill();
        int n;
        dead_R = 1'b1;
        pos_reset = 1'b1;
        repeat (2) tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL pos_over_kill got=%h exp=%h", got, e); end
        exp_q.push_back(mk(0, 0, 1, WIN_NONE, 0, 1));
        wait_event("pos_kill_scroll", n);
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL pos_kill_scroll got=%h exp=%h", got, e); end
        dead_R = 1'b0;
        pos_reset = 1'b0;
        repeat (RF) pulse_tick();
        exp_q.push_back(mk(1, 1, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL pos_kill_respawn got=%h exp=%h", got, e); end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL start_ignored got=%h exp=%h", got, e); end
    endtask

    task automatic test_saturation();
        int n;
        for (int k = 1; k <= 16; k++) begin
            dead_R = 1'b1;
            if (exp_sl < 15) exp_sl++;
            exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
            wait_event("sat_kill", n);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL sat_kill_%0d got=%h exp=%h", k, got, e); end
            dead_R = 1'b0;
            repeat (RF) pulse_tick();
            exp_q.push_back(mk(0, 1, 0, WIN_NONE, 0, 0));
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL sat_respawn_%0d got=%h exp=%h", k, got, e); end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        dead_L = 1'b1;
        exp_sr++;
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        wait_event("mid_kill", n);
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL mid_kill got=%h exp=%h", got, e); end
        dead_L = 1'b0;
        repeat (2) pulse_tick();
        #2;
        reset = 1'b0;
        #1;
        exp_sl = 0;
        exp_sr = 0;
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL reset_mid_wait got=%h exp=%h", got, e); end
        repeat (2) pulse_tick();
        reset = 1'b1;
        repeat (RF + 1) pulse_tick();
        exp_q.push_back(mk(0, 0, 0, WIN_NONE, 0, 1));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL idle_after_reset got=%h exp=%h", got, e); end
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(mk(1, 1, 0, WIN_NONE, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL start_after_reset got=%h exp=%h", got, e); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_single_kill();
        test_double_kill();
        test_advance();
        test_pos_and_kill();
        test_saturation();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/round_control.md
Name: round_control

Overview:
- Round and match sequencer that sits directly downstream of the hit/collision stage.
- Consumes `dead_L`, `dead_R`, `pos_reset` and `board_controller`, and turns kills and screen-edge exits into score updates, a frame-timed respawn delay, board-scroll requests and match-over detection.
- Drives `freeze` to the player movement/input logic, respawn pulses to the position registers, and score/winner to the HUD renderer.

Parameters:
- RESPAWN_FRAMES, 60: number of `frame_tick` pulses that `freeze` is held after a kill or board change.
- WIN_BOARD, 3: `board_controller` magnitude (signed) that ends the match.
- SCORE_W, 4: width of each score counter.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync start)
- start  in  1  one-cycle start/restart request from the button debouncer
- dead_L  in  1  left player hit (level, from hit stage)
- dead_R  in  1  right player hit (level)
- pos_reset  in  1  player reached screen edge (level)
- board_controller  in  3  board index, two's complement, −4..+3
- freeze  out  1  1 = player motion and attacks disabled
- respawn_L  out  1  one-cycle pulse: reload left player start position
- respawn_R  out  1  one-cycle pulse: reload right player start position
- scroll  out  1  one-cycle pulse: background redraw for the new board
- score_L  out  SCORE_W  left kills
- score_R  out  SCORE_W  right kills
- winner  out  2  00 none, 01 left, 10 right
- game_over  out  1  match finished

Behaviour:
- Reset (reset=0, async): state IDLE, freeze=1, all pulses 0, scores 0, winner 00, game_over 0, counters 0.
- Inputs `dead_L`, `dead_R` and `pos_reset` are registered once; rising-edge detect is applied to the registered copies. All events below are rising edges.
- IDLE: on `start` → PLAY. Same cycle: respawn_L=respawn_R=1, freeze←0.
- PLAY (freeze=0). Priority: pos_reset > double kill > single kill.
  - pos_reset edge → ADVANCE, freeze←1.
  - dead_L and dead_R edges in the same cycle → no score change, both marked for respawn → WAIT.
  - dead_L edge → score_R+1 (saturates at all-ones), mark L → WAIT.
  - dead_R edge → score_L+1 (saturating), mark R → WAIT.
  - Entering WAIT: freeze←1, frame counter cleared.
- WAIT: count `frame_tick` pulses.
  - When the count reaches RESPAWN_FRAMES−1 and `frame_tick`=1: one-cycle pulse on the marked respawn output(s), clear the marks, freeze←0 → PLAY.
  - Edges arriving in WAIT are discarded; the edge detector still tracks them, so a level held through WAIT does not retrigger on exit.
- ADVANCE: wait exactly 2 clk (board_controller lags pos_reset by one register stage), then sample board_controller as signed.
  - ≥ +WIN_BOARD → winner=01 → OVER.
  - ≤ −WIN_BOARD → winner=10 → OVER.
  - Otherwise: scroll pulse, mark both players → WAIT.
- OVER: game_over=1, freeze=1, scores held.
  - On `start`: scores←0, winner←00, game_over←0, both respawn pulses, freeze←0 → PLAY.
  - `start` in any state other than IDLE/OVER is ignored.
- frame_tick and a kill edge in the same cycle: the kill is processed and the counter starts from 0 (that tick does not count).
- RESPAWN_FRAMES=1: respawn on the first frame_tick after entry.
- Reset asserted mid-WAIT/ADVANCE: everything returns to reset values immediately; no pending pulse is emitted.
- Counter width: $clog2(RESPAWN_FRAMES+1). Score arithmetic is unsigned; board comparison is signed 3-bit.

Decomposition:
- Shared package (game_pkg): state encoding localparams (IDLE, PLAY, WAIT, ADVANCE, OVER), winner codes, the screen constants already shared by the game (1024 width, 40 edge margin, 64 player width).
- One natural sub-module: edge_detect (register plus rising-edge pulse), instantiated 3×.
- FSM, counters and scores stay in round_control.

Test Plan:
- Reset release, start pulse → respawn_L=respawn_R=1 for 1 cycle, freeze 1→0, scores 0/0.
- dead_L held high 5 cycles in PLAY, RESPAWN_FRAMES=4 → score_R=1 exactly once, freeze=1; respawn_L only on the 4th frame_tick, then PLAY; no second score while dead_L stays high.
- dead_L and dead_R rising in the same cycle → scores unchanged; both respawn pulses after 4 frame_ticks.
- pos_reset with board_controller going 1→2 → after 2 clk, scroll=1 for one cycle; board 2→3 → winner=01, game_over=1; start → scores 0, winner 00, PLAY.
- pos_reset and dead_R in the same cycle → ADVANCE taken, score_L unchanged; score_L=15 plus another dead_R → stays 15.
- Assert reset mid-WAIT at frame 2 of 4 → all outputs at reset values immediately; state IDLE after release.
